// File: rtl/life_engine.sv
// Game-of-Life generation engine: serially computes the next board into a work
// buffer and commits it to the display board only on a swap strobe.
module life_engine #(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8,
    parameter logic [BOARD_W*BOARD_H-1:0] INIT_PATTERN = 64'h50A8_8888_0609_0909,
    parameter int GEN_W = 16,
    localparam int N  = BOARD_W * BOARD_H,
    localparam int XW = $clog2(BOARD_W),
    localparam int YW = $clog2(BOARD_H),
    localparam int CW = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             swap,
    input  logic             load,
    input  logic             wrap,
    input  logic [XW-1:0]    rd_x,
    input  logic [YW-1:0]    rd_y,
    output logic             rd_cell,
    output logic             busy,
    output logic             pending,
    output logic             done,
    output logic             stable,
    output logic [GEN_W-1:0] gen_count,
    output logic [CW-1:0]    alive_count
);

    localparam int IW = $clog2(N);

    function automatic int popcount(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    localparam logic [CW-1:0] INIT_POP = CW'(popcount(INIT_PATTERN));

    // Neighbour (x+dx, y+dy) of board b; off-board cells are dead unless wrapping.
    function automatic logic neighbour(input logic [N-1:0] b, input int x, input int y,
                                       input int dx, input int dy, input logic wr);
        int nx;
        int ny;
        logic on_board;
        nx = x + dx;
        ny = y + dy;
        if (wr) begin
            if (nx < 0) nx = BOARD_W - 1;
            else if (nx >= BOARD_W) nx = 0;
            if (ny < 0) ny = BOARD_H - 1;
            else if (ny >= BOARD_H) ny = 0;
        end
        on_board = (nx >= 0) && (nx < BOARD_W) && (ny >= 0) && (ny < BOARD_H);
        if (on_board) return b[IW'(ny * BOARD_W + nx)];
        return 1'b0;
    endfunction

    typedef enum logic [1:0] {IDLE, COMPUTE, PENDING} state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  disp;
    logic [N-1:0]  work;
    logic [IW-1:0] idx;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          wrap_q;
    logic [CW-1:0] pop_acc;
    logic          diff;
    logic [3:0]    ncount;
    logic          cur;
    logic          next_cell;
    logic          last;

    assign last = (idx == IW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (step) state_next = COMPUTE;
                COMPUTE: if (last) state_next = PENDING;
                PENDING: if (swap) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state == COMPUTE);
        pending = (state == PENDING);
    end

    always_comb begin
        ncount = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0)
                    ncount = ncount + {3'b000, neighbour(disp, int'(cx), int'(cy), dx, dy, wrap_q)};
            end
        end
        cur       = disp[idx];
        next_cell = (ncount == 4'd3) || (cur && (ncount == 4'd2));
    end

    always_comb begin
        rd_cell = 1'b0;
        if (int'(rd_x) < BOARD_W && int'(rd_y) < BOARD_H)
            rd_cell = disp[IW'(int'(rd_y) * BOARD_W + int'(rd_x))];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp        <= INIT_PATTERN;
            work        <= '0;
            idx         <= '0;
            cx          <= '0;
            cy          <= '0;
            wrap_q      <= 1'b0;
            pop_acc     <= '0;
            diff        <= 1'b0;
            done        <= 1'b0;
            stable      <= 1'b0;
            gen_count   <= '0;
            alive_count <= INIT_POP;
        end else if (load) begin
            disp        <= INIT_PATTERN;
            work        <= '0;
            idx         <= '0;
            cx          <= '0;
            cy          <= '0;
            pop_acc     <= '0;
            diff        <= 1'b0;
            done        <= 1'b0;
            stable      <= 1'b0;
            gen_count   <= '0;
            alive_count <= INIT_POP;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step) begin
                        wrap_q  <= wrap;
                        idx     <= '0;
                        cx      <= '0;
                        cy      <= '0;
                        pop_acc <= '0;
                        diff    <= 1'b0;
                    end
                end
                COMPUTE: begin
                    work[idx] <= next_cell;
                    pop_acc   <= pop_acc + {{(CW-1){1'b0}}, next_cell};
                    diff      <= diff | (next_cell ^ cur);
                    if (!last) begin
                        idx <= idx + 1'b1;
                        // Row/column tracked alongside idx to avoid a divider.
                        if (cx == XW'(BOARD_W - 1)) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (swap) begin
                        disp        <= work;
                        alive_count <= pop_acc;
                        stable      <= ~diff;
                        gen_count   <= gen_count + 1'b1;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
